// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO responder: address map, region
// enumeration and FSM state encoding.
package mio_pkg;

    localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
    localparam logic [31:0] GPIO_IN_ADDR  = 32'hE000_0000;
    localparam logic [31:0] GPIO_OUT_ADDR = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR      = 32'hF000_0004;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_GPIO_IN,
        REG_GPIO_OUT,
        REG_CNT,
        REG_NONE
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mio_if.sv
// CPU-side request/response bus of the memory/IO responder.
interface mio_if;

    logic        cpu_req;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mio_ready;

    modport master (
        output cpu_req, mem_w, addr, wdata,
        input  rdata, mio_ready
    );

    modport slave (
        input  cpu_req, mem_w, addr, wdata,
        output rdata, mio_ready
    );

endinterface

// File: rtl/mio_addr_decode.sv
// Combinational address decoder: byte address to region, with misaligned
// or unmapped addresses reported as an error.
module mio_addr_decode
    import mio_pkg::*;
(
    input  logic [31:0] addr_i,
    output region_e     region_o,
    output logic        err_o
);

    always_comb begin
        region_o = REG_NONE;
        if (addr_i[1:0] == 2'b00) begin
            if (addr_i[31:12] == RAM_BASE[31:12]) begin
                region_o = REG_RAM;
            end else if (addr_i == GPIO_IN_ADDR) begin
                region_o = REG_GPIO_IN;
            end else if (addr_i == GPIO_OUT_ADDR) begin
                region_o = REG_GPIO_OUT;
            end else if (addr_i == CNT_ADDR) begin
                region_o = REG_CNT;
            end
        end
    end

    assign err_o = (region_o == REG_NONE);

endmodule

// File: rtl/mio_responder.sv
// Memory/IO responder: serves CPU requests from a synchronous RAM, a GPIO
// pair and a free-running counter, with per-region wait states.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for cpu_req; request fields latched on acceptance
// ST_ACCESS | wait counter runs down; RAM addressed, RAM write issued
// ST_RESP   | one-cycle mio_ready pulse with read data; register writes
//           | and bus_err take effect on entry
module mio_responder
    import mio_pkg::*;
#(
    parameter int unsigned WAIT_RAM = 1,
    parameter int unsigned WAIT_IO  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    mio_if.slave        bus,
    output logic [9:0]  ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic [31:0] gpio_out,
    input  logic [31:0] gpio_in,
    output logic        bus_err
);

    localparam logic [3:0] WAIT_RAM_C = 4'(WAIT_RAM);
    localparam logic [3:0] WAIT_IO_C  = 4'(WAIT_IO);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [9:0]  widx_q, widx_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_w_q, mem_w_d;
    region_e     region_q, region_d;
    logic        err_q, err_d;
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;

    region_e     dec_region;
    logic        dec_err;
    logic [31:0] rdata;

    mio_addr_decode u_decode (
        .addr_i   (bus.addr),
        .region_o (dec_region),
        .err_o    (dec_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            widx_q    <= '0;
            wdata_q   <= '0;
            mem_w_q   <= 1'b0;
            region_q  <= REG_NONE;
            err_q     <= 1'b0;
            gpio_q    <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            mem_w_q   <= mem_w_d;
            region_q  <= region_d;
            err_q     <= err_d;
            gpio_q    <= gpio_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        mem_w_d   = mem_w_q;
        region_d  = region_q;
        err_d     = err_q;
        gpio_d    = gpio_q;
        cnt_d     = cnt_q + 32'd1;
        bus_err_d = bus_err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    state_d  = ST_ACCESS;
                    widx_d   = bus.addr[11:2];
                    wdata_d  = bus.wdata;
                    mem_w_d  = bus.mem_w;
                    region_d = dec_region;
                    err_d    = dec_err;
                    wait_d   = (dec_region == REG_RAM) ? WAIT_RAM_C : WAIT_IO_C;
                end
            end
            ST_ACCESS: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_RESP;
                    // Register side effects happen only here, once per transaction.
                    if (err_q) begin
                        bus_err_d = 1'b1;
                    end else if (mem_w_q) begin
                        if (region_q == REG_GPIO_OUT) gpio_d = wdata_q;
                        if (region_q == REG_CNT)      cnt_d  = wdata_q;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // wait_q still equals its load value only in the first ACCESS cycle.
    assign ram_we   = (state_q == ST_ACCESS) && (region_q == REG_RAM) && mem_w_q
                      && (wait_q == WAIT_RAM_C);
    assign ram_addr = widx_q;
    assign ram_din  = wdata_q;

    always_comb begin
        rdata = '0;
        if ((state_q == ST_RESP) && !mem_w_q) begin
            case (region_q)
                REG_RAM:      rdata = ram_dout;
                REG_GPIO_IN:  rdata = gpio_in;
                REG_GPIO_OUT: rdata = gpio_q;
                REG_CNT:      rdata = cnt_q;
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.rdata     = rdata;
    assign bus.mio_ready = (state_q == ST_RESP);
    assign gpio_out      = gpio_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mio_responder.sv
// Randomised self-checking bench for mio_responder against a transaction-level
// model of the address map, wait states, counter and sticky error flag.
module tb_mio_responder;

    localparam int WAIT_RAM = 1;
    localparam int WAIT_IO  = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in = '0;
    logic        bus_err;

    mio_if bus ();

    mio_responder #(.WAIT_RAM(WAIT_RAM), .WAIT_IO(WAIT_IO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    // Environment RAM: synchronous, read-first, one-cycle read latency.
    logic [31:0] mem [1024] = '{default: 32'h0};
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int unsigned cyc = 0;
    int          we_cnt = 0;
    logic [9:0]  we_addr = '0;
    int          ready_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= ram_addr;
        end
        if (bus.mio_ready) ready_cnt <= ready_cnt + 1;
    end

    // Reference model state
    logic [31:0] ref_mem [1024] = '{default: 32'h0};
    logic [31:0] ref_gpio = '0;
    logic        ref_err = 1'b0;
    int unsigned cnt_l = 0;
    logic [31:0] cnt_v = '0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // 0 RAM, 1 gpio_in, 2 gpio_out, 3 counter, 4 error
    function automatic int region_of(input logic [31:0] a);
        if (a[1:0] != 2'b00)         return 4;
        if (a < 32'h0000_1000)       return 0;
        if (a == 32'hE000_0000)      return 1;
        if (a == 32'hF000_0000)      return 2;
        if (a == 32'hF000_0004)      return 3;
        return 4;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // idle cycle that follows the response.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit keep, input string tag);
        int          k;
        int          rg;
        int          lat_exp;
        int          we0;
        logic [31:0] exp;
        rg      = region_of(a);
        lat_exp = 2 + ((rg == 0) ? WAIT_RAM : WAIT_IO);
        we0     = we_cnt;
        bus.cpu_req = 1'b1;
        bus.mem_w   = w;
        bus.addr    = a;
        bus.wdata   = d;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        while (!bus.mio_ready && k < 40) begin
            bus.addr  = $urandom;
            bus.wdata = $urandom;
            bus.mem_w = 1'($urandom_range(0, 1));
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk($sformatf("%s.latency", tag), 32'(k + 1), 32'(lat_exp));
        if (!w) begin
            case (rg)
                0:       exp = ref_mem[a[11:2]];
                1:       exp = gpio_in;
                2:       exp = ref_gpio;
                3:       exp = cnt_v + (cyc - cnt_l);
                default: exp = '0;
            endcase
            chk($sformatf("%s.rdata", tag), bus.rdata, exp);
        end
        if (rg == 4) begin
            ref_err = 1'b1;
        end else if (w) begin
            if (rg == 0) ref_mem[a[11:2]] = d;
            if (rg == 2) ref_gpio = d;
            if (rg == 3) begin
                cnt_l = cyc;
                cnt_v = d;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("%s.ready_pulse", tag), 32'(bus.mio_ready), 32'd0);
        chk($sformatf("%s.rdata_idle", tag), bus.rdata, 32'd0);
        chk($sformatf("%s.gpio_out", tag), gpio_out, ref_gpio);
        chk($sformatf("%s.bus_err", tag), 32'(bus_err), 32'(ref_err));
        chk($sformatf("%s.ram_we_count", tag), 32'(we_cnt - we0),
            (w && rg == 0) ? 32'd1 : 32'd0);
        if (!keep) bus.cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0;
        logic [31:0] a;
        bus.cpu_req = 1'b0;
        bus.mem_w   = 1'b0;
        bus.addr    = '0;
        bus.wdata   = '0;
        repeat (3) @(negedge clk);
        chk("reset.mio_ready", 32'(bus.mio_ready), 32'd0);
        chk("reset.rdata", bus.rdata, 32'd0);
        chk("reset.ram_we", 32'(ram_we), 32'd0);
        chk("reset.ram_addr", 32'(ram_addr), 32'd0);
        chk("reset.ram_din", ram_din, 32'd0);
        chk("reset.gpio_out", gpio_out, 32'd0);
        chk("reset.bus_err", 32'(bus_err), 32'd0);
        rst_n = 1'b1;
        cnt_l = cyc;
        cnt_v = '0;
        @(negedge clk);

        // RAM write then read back
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "ram_wr");
        chk("ram_wr.ram_addr", 32'(we_addr), 32'd4);
        chk("ram_wr.stored", mem[4], 32'hDEAD_BEEF);
        txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, "ram_rd");

        // GPIO
        txn(1'b1, 32'hF000_0000, 32'h0000_00A5, 1'b0, "gpio_wr");
        gpio_in = 32'h0000_1234;
        txn(1'b0, 32'hE000_0000, 32'h0, 1'b0, "gpio_in_rd");
        txn(1'b1, 32'hE000_0000, 32'h5555_5555, 1'b0, "gpio_in_wr");
        txn(1'b0, 32'hF000_0000, 32'h0, 1'b0, "gpio_out_rd");

        // Counter load near wrap, idle, then read
        txn(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 1'b0, "cnt_wr");
        repeat (2) @(negedge clk);
        txn(1'b0, 32'hF000_0004, 32'h0, 1'b0, "cnt_rd");

        // Error accesses leave RAM untouched and set the sticky flag
        txn(1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, "ram0_wr");
        txn(1'b0, 32'h1000_0000, 32'h0, 1'b0, "err_rd");
        txn(1'b1, 32'h0000_0002, 32'h0BAD_0BAD, 1'b0, "err_wr");
        txn(1'b0, 32'h0000_0000, 32'h0, 1'b0, "ram0_rd");
        chk("err.mem0", mem[0], 32'h1111_1111);

        // Reset during the access phase of a GPIO write
        bus.cpu_req = 1'b1;
        bus.mem_w   = 1'b1;
        bus.addr    = 32'hF000_0000;
        bus.wdata   = 32'h0000_5A5A;
        @(posedge clk);
        @(negedge clk);
        r0 = ready_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.mio_ready", 32'(bus.mio_ready), 32'd0);
        chk("rst_mid.gpio_out", gpio_out, 32'd0);
        chk("rst_mid.bus_err", 32'(bus_err), 32'd0);
        chk("rst_mid.ram_din", ram_din, 32'd0);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_l = cyc;
        cnt_v = '0;
        ref_gpio = '0;
        ref_err = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid.no_ready", 32'(ready_cnt - r0), 32'd0);
        chk("rst_mid.gpio_after", gpio_out, 32'd0);
        txn(1'b1, 32'hF000_0000, 32'h0000_0077, 1'b0, "post_rst_wr");
        txn(1'b0, 32'hF000_0004, 32'h0, 1'b0, "post_rst_cnt");

        // Back-to-back reads with cpu_req held high
        r0 = ready_cnt;
        txn(1'b0, 32'h0000_0010, 32'h0, 1'b1, "b2b0");
        txn(1'b0, 32'hE000_0000, 32'h0, 1'b1, "b2b1");
        txn(1'b0, 32'hF000_0000, 32'h0, 1'b0, "b2b2");
        chk("b2b.ready_count", 32'(ready_cnt - r0), 32'd3);

        // Random mix across all regions
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'b00};
                2:       a = 32'hE000_0000;
                3:       a = 32'hF000_0000;
                4:       a = 32'hF000_0004;
                default: a = ($urandom_range(0, 1) == 1) ? {4'h5, 28'($urandom)}
                                                         : (32'hF000_0000 | 32'($urandom_range(1, 3)));
            endcase
            gpio_in = $urandom;
            txn(1'($urandom_range(0, 1)), a, $urandom, (i < 59) && ($urandom_range(0, 1) == 1),
                $sformatf("rnd%0d", i));
        end
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
